sata_link_arbt_mc: RTL and testbench

Parametrised successor of the single-requester SATA link arbiter. Arbitrates link ownership between NUM_CH transport transmit requesters and the received X_RDY path. Adds selectable host/device collision priority, round-robin or fixed channel selection, a per-grant watchdog, a post-transfer gap, and re-arming of the start-up guard on PHYRDY loss. Sits between the transport queues and the link TX/RX state machines.

---
 rtl/sata_link_arbt_mc.sv | 199 +++++++++++++++++++
 tb/tb_sata_link_arbt_mc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sata_link_arbt_mc.sv
// Multi-channel SATA link arbiter: grants the link to one of NUM_CH transport
// transmit requesters or to the received X_RDY path. Start-up guard,
// roll-insert pause, per-grant watchdog and post-transfer gap.
//
// state | meaning
// IDLE  | waiting for an eligible TX request or X_RDY
// WR    | TX grant active, wr_gnt/wr_ch hold the granted channel
// RD    | RX grant active
// GAP   | quiet period after a grant, no new grants

package sata_link_pkg;
  typedef enum logic [3:0] {
    prim_none, align, sync, x_rdy, r_rdy, r_ip, r_ok,
    r_err, sof, eof, wtrm, hold, holda, cont
  } sata_p_t;
endpackage

module sata_link_arbt_mc
  import sata_link_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int START_CYC   = 150,
  parameter int ROLL_HOLD   = 1,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 65536,
  parameter int ROLE        = 1,
  parameter int RR_EN       = 1,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] tx_req,
  input  sata_p_t           rx_dat_type,
  input  logic              phyrdy,
  input  logic              roll_insert,
  output logic              wr_req,
  output logic [NUM_CH-1:0] wr_gnt,
  output logic [CH_W-1:0]   wr_ch,
  input  logic              wr_cpl,
  input  logic              wr_no_busy,
  output logic              rd_req,
  input  logic              rd_cpl,
  output logic              arbt_rdy,
  output logic              timeout_err
);

  localparam int GW  = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam int WW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GPW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0]  G_LAST   = GW'(START_CYC - 1);
  localparam logic [WW-1:0]  WD_LAST  = WW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [GPW-1:0] GAP_LAST = GPW'(GAP_CYC - 1);
  localparam logic [3:0]     HOLD_V   = 4'(ROLL_HOLD);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_WR   = 4'b0010,
    S_RD   = 4'b0100,
    S_GAP  = 4'b1000
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   g_cnt;
  logic            g_exp;
  logic [3:0]      stretch;
  logic [WW-1:0]   wd_cnt;
  logic [GPW-1:0]  gap_cnt;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] sel_idx;
  logic            pause, tx_any, xrdy, wd_exp, timeout_hit;

  assign arbt_rdy    = g_exp && phyrdy;
  assign pause       = roll_insert || (stretch != 4'd0);
  assign tx_any      = |tx_req;
  assign xrdy        = (rx_dat_type == x_rdy);
  assign wd_exp      = (TIMEOUT_CYC != 0) && (wd_cnt == WD_LAST);
  assign wr_req      = (state == S_WR);
  assign rd_req      = (state == S_RD);
  assign timeout_err = timeout_hit;

  // Start-up guard; any PHYRDY loss re-arms it from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_cnt <= '0;
      g_exp <= 1'b0;
    end else if (!phyrdy) begin
      g_cnt <= '0;
      g_exp <= 1'b0;
    end else if (!g_exp) begin
      if (g_cnt == G_LAST) g_exp <= 1'b1;
      else                 g_cnt <= g_cnt + GW'(1);
    end
  end

  // Pause stretch: held at ROLL_HOLD while roll_insert is high, so the
  // countdown effectively starts at its falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    stretch <= 4'd0;
    else if (roll_insert)       stretch <= HOLD_V;
    else if (stretch != 4'd0)   stretch <= stretch - 4'd1;
  end

  // Channel pick: scanning offsets downward leaves the closest requester
  // at or after the starting point (pointer for RR, index 0 for fixed).
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      int j;
      logic [CH_W-1:0] idx;
      j = (RR_EN != 0) ? int'(rr_ptr) + i : i;
      if (j >= NUM_CH) j = j - NUM_CH;
      idx = CH_W'(j);
      if (tx_req[idx]) sel_idx = idx;
    end
  end

  // Next-state logic; PHYRDY loss overrides every other transition.
  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (arbt_rdy && !pause) begin
          if (ROLE == 1) begin
            if (tx_any)    state_nxt = S_WR;
            else if (xrdy) state_nxt = S_RD;
          end else begin
            if (xrdy)        state_nxt = S_RD;
            else if (tx_any) state_nxt = S_WR;
          end
        end
      end
      S_WR: begin
        if (wr_no_busy)  state_nxt = S_RD;
        else if (wr_cpl) state_nxt = S_GAP;
        else if (wd_exp) begin
          timeout_hit = 1'b1;
          state_nxt   = S_GAP;
        end
      end
      S_RD: begin
        if (rd_cpl) state_nxt = S_GAP;
        else if (wd_exp) begin
          timeout_hit = 1'b1;
          state_nxt   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!phyrdy && state != S_IDLE) begin
      state_nxt   = S_IDLE;
      timeout_hit = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Watchdog: restarts on every entry into WR or RD, including WR->RD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wd_cnt <= '0;
    else if ((state_nxt == S_WR || state_nxt == S_RD) && state_nxt == state)
      wd_cnt <= wd_cnt + WW'(1);
    else
      wd_cnt <= '0;
  end

  // Gap down-counter, loaded on entry to GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      gap_cnt <= '0;
    else if (state_nxt == S_GAP && state != S_GAP) gap_cnt <= GAP_LAST;
    else if (gap_cnt != '0)                        gap_cnt <= gap_cnt - GPW'(1);
  end

  // Grant capture and round-robin pointer advance on IDLE->WR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_gnt <= '0;
      wr_ch  <= '0;
      rr_ptr <= '0;
    end else if (state == S_IDLE && state_nxt == S_WR) begin
      wr_gnt <= NUM_CH'(1) << sel_idx;
      wr_ch  <= sel_idx;
      if (RR_EN != 0)
        rr_ptr <= (sel_idx == CH_W'(NUM_CH - 1)) ? '0 : sel_idx + CH_W'(1);
    end else if (state_nxt != S_WR) begin
      wr_gnt <= '0;
      wr_ch  <= '0;
    end
  end

endmodule

// File: tb/tb_sata_link_arbt_mc.sv
// Scoreboard bench: two arbiters (device/round-robin and host/fixed) share
// randomized stimulus; a behavioural model predicts grant start/end and
// timeout events into per-DUT queues that a negedge monitor drains.
module tb_sata_link_arbt_mc;
  import sata_link_pkg::*;

  localparam int NCH   = 4;
  localparam int START = 150;
  localparam int HOLDC = 3;
  localparam int GAPC  = 2;
  localparam int TMO   = 16;
  localparam int NCYC  = 20000;

  localparam int K_WEND = 0, K_REND = 1, K_WST = 2, K_RST = 3, K_TO = 4;
  localparam int O_NONE = 0, O_TX = 1, O_RX = 2, O_GAP = 3;

  typedef struct { int kind; int cyc; int ch; } ev_t;
  typedef struct { int guard; int hold; int own; int age; int gap; int ptr; int ch; } ms_t;
  typedef struct { bit to; bit wend; bit rend; bit wst; bit rst_; int ch; } me_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [NCH-1:0] tx_req = '0;
  sata_p_t rx_dat_type = sync;
  logic phyrdy = 1'b0, roll_insert = 1'b0;
  logic wr_cpl = 1'b0, wr_no_busy = 1'b0, rd_cpl = 1'b0;

  logic wr_req_a, rd_req_a, arbt_rdy_a, timeout_err_a;
  logic wr_req_b, rd_req_b, arbt_rdy_b, timeout_err_b;
  logic [NCH-1:0] wr_gnt_a, wr_gnt_b;
  logic [1:0] wr_ch_a, wr_ch_b;

  ev_t qa[$], qb[$];
  int n_chk = 0, n_fail = 0;
  int cyc = -1;
  bit exp_rdy = 1'b0;
  bit prev_wr[2], prev_rd[2];
  logic [NCH-1:0] held_gnt[2];

  always #5 clk = ~clk;

  sata_link_arbt_mc #(.NUM_CH(NCH), .START_CYC(START), .ROLL_HOLD(HOLDC), .GAP_CYC(GAPC),
    .TIMEOUT_CYC(TMO), .ROLE(1), .RR_EN(1)) u_a (
    .clk(clk), .rst(rst), .tx_req(tx_req), .rx_dat_type(rx_dat_type), .phyrdy(phyrdy),
    .roll_insert(roll_insert), .wr_req(wr_req_a), .wr_gnt(wr_gnt_a), .wr_ch(wr_ch_a),
    .wr_cpl(wr_cpl), .wr_no_busy(wr_no_busy), .rd_req(rd_req_a), .rd_cpl(rd_cpl),
    .arbt_rdy(arbt_rdy_a), .timeout_err(timeout_err_a));

  sata_link_arbt_mc #(.NUM_CH(NCH), .START_CYC(START), .ROLL_HOLD(HOLDC), .GAP_CYC(GAPC),
    .TIMEOUT_CYC(TMO), .ROLE(0), .RR_EN(0)) u_b (
    .clk(clk), .rst(rst), .tx_req(tx_req), .rx_dat_type(rx_dat_type), .phyrdy(phyrdy),
    .roll_insert(roll_insert), .wr_req(wr_req_b), .wr_gnt(wr_gnt_b), .wr_ch(wr_ch_b),
    .wr_cpl(wr_cpl), .wr_no_busy(wr_no_busy), .rd_req(rd_req_b), .rd_cpl(rd_cpl),
    .arbt_rdy(arbt_rdy_b), .timeout_err(timeout_err_b));

  task automatic chk(input string nm, input bit ok, input int got, input int req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d required=%0d", nm, cyc, got, req);
    end
  endtask

  task automatic sb_cmp(input int d, input int kind, input int ch);
    ev_t e;
    n_chk++;
    if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
      n_fail++;
      $display("FAIL sb%0d unexpected event kind=%0d ch=%0d cyc=%0d, required no event", d, kind, ch, cyc);
    end else begin
      if (d == 0) e = qa.pop_front();
      else        e = qb.pop_front();
      if (e.kind != kind || e.cyc != cyc || (kind == K_WST && e.ch != ch)) begin
        n_fail++;
        $display("FAIL sb%0d got kind=%0d cyc=%0d ch=%0d, required kind=%0d cyc=%0d ch=%0d",
                 d, kind, cyc, ch, e.kind, e.cyc, e.ch);
      end
    end
  endtask

  task automatic observe(input int d, input logic wr, input logic rd, input logic to,
                         input logic [NCH-1:0] gnt, input logic [1:0] ch);
    logic [NCH-1:0] oh;
    oh = 4'b0001 << ch;
    if (!wr && prev_wr[d]) sb_cmp(d, K_WEND, 0);
    if (!rd && prev_rd[d]) sb_cmp(d, K_REND, 0);
    if (wr && !prev_wr[d]) begin
      sb_cmp(d, K_WST, int'(ch));
      chk("gnt_onehot", gnt == oh, int'(gnt), int'(oh));
      held_gnt[d] = gnt;
    end else if (wr) begin
      chk("gnt_held", gnt == held_gnt[d], int'(gnt), int'(held_gnt[d]));
    end
    if (rd && !prev_rd[d]) sb_cmp(d, K_RST, 0);
    if (to) sb_cmp(d, K_TO, 0);
    chk("wr_rd_excl", !(wr && rd), int'(wr && rd), 0);
    prev_wr[d] = wr;
    prev_rd[d] = rd;
  endtask

  // Reference model: one clock of link ownership from the spec's rules.
  function automatic void mstep(input int role, input int rr, input ms_t s,
      input logic [NCH-1:0] tx, input bit xr, input bit phy, input bit roll,
      input bit wc, input bit wnb, input bit rc, output ms_t n, output me_t e);
    bit rdy, pause;
    int nxt, c;
    n = s;
    e = '{default: 0};
    rdy   = phy && (s.guard >= START);
    pause = roll || (s.hold > 0);
    nxt   = s.own;
    if (s.own == O_NONE) begin
      if (rdy && !pause) begin
        if (role == 1) begin
          if (tx != 0) nxt = O_TX; else if (xr) nxt = O_RX;
        end else begin
          if (xr) nxt = O_RX; else if (tx != 0) nxt = O_TX;
        end
      end
    end else if (s.own == O_TX) begin
      if (wnb) nxt = O_RX;
      else if (wc) nxt = O_GAP;
      else if (s.age == TMO - 1) begin e.to = 1; nxt = O_GAP; end
    end else if (s.own == O_RX) begin
      if (rc) nxt = O_GAP;
      else if (s.age == TMO - 1) begin e.to = 1; nxt = O_GAP; end
    end else begin
      if (s.gap <= 1) nxt = O_NONE;
    end
    if (!phy && s.own != O_NONE) begin nxt = O_NONE; e.to = 0; end
    if (nxt == O_TX && s.own != O_TX) begin
      c = -1;
      for (int off = 0; off < NCH; off++) begin
        int idx;
        idx = (rr != 0) ? (s.ptr + off) % NCH : off;
        if (c < 0 && tx[idx[1:0]]) c = idx;
      end
      n.ch = c;
      if (rr != 0) n.ptr = (c + 1) % NCH;
    end
    n.age   = (nxt == s.own && (nxt == O_TX || nxt == O_RX)) ? s.age + 1 : 0;
    n.gap   = (nxt == O_GAP) ? ((s.own == O_GAP) ? s.gap - 1 : GAPC) : 0;
    n.guard = !phy ? 0 : ((s.guard < START) ? s.guard + 1 : s.guard);
    n.hold  = roll ? HOLDC : ((s.hold > 0) ? s.hold - 1 : 0);
    n.own   = nxt;
    e.wend  = (s.own == O_TX && nxt != O_TX);
    e.rend  = (s.own == O_RX && nxt != O_RX);
    e.wst   = (nxt == O_TX && s.own != O_TX);
    e.rst_  = (nxt == O_RX && s.own != O_RX);
    e.ch    = n.ch;
  endfunction

  task automatic push_ev(input int d, input me_t e, input int k);
    ev_t x;
    if (e.to)   begin x = '{K_TO,   k,     0};    if (d == 0) qa.push_back(x); else qb.push_back(x); end
    if (e.wend) begin x = '{K_WEND, k + 1, 0};    if (d == 0) qa.push_back(x); else qb.push_back(x); end
    if (e.rend) begin x = '{K_REND, k + 1, 0};    if (d == 0) qa.push_back(x); else qb.push_back(x); end
    if (e.wst)  begin x = '{K_WST,  k + 1, e.ch}; if (d == 0) qa.push_back(x); else qb.push_back(x); end
    if (e.rst_) begin x = '{K_RST,  k + 1, 0};    if (d == 0) qa.push_back(x); else qb.push_back(x); end
  endtask

  // Monitor: mid-cycle sampling of both DUTs plus fixed start-up timing.
  always @(negedge clk) begin
    if (!rst) begin
      observe(0, wr_req_a, rd_req_a, timeout_err_a, wr_gnt_a, wr_ch_a);
      observe(1, wr_req_b, rd_req_b, timeout_err_b, wr_gnt_b, wr_ch_b);
      chk("arbt_rdy_a", arbt_rdy_a == exp_rdy, int'(arbt_rdy_a), int'(exp_rdy));
      chk("arbt_rdy_b", arbt_rdy_b == exp_rdy, int'(arbt_rdy_b), int'(exp_rdy));
      if (cyc < 151) chk("startup_no_grant", !(wr_req_a || rd_req_a), int'(wr_req_a), 0);
      if (cyc == 149) chk("startup_rdy_149", arbt_rdy_a == 1'b0, int'(arbt_rdy_a), 0);
      if (cyc == 150) chk("startup_rdy_150", arbt_rdy_a == 1'b1, int'(arbt_rdy_a), 1);
      if (cyc == 151) begin
        chk("startup_wr_req_a", wr_req_a == 1'b1, int'(wr_req_a), 1);
        chk("startup_wr_gnt_a", wr_gnt_a == 4'b0001, int'(wr_gnt_a), 1);
        chk("startup_wr_ch_a", wr_ch_a == 2'd0, int'(wr_ch_a), 0);
        chk("startup_wr_req_b", wr_req_b == 1'b1, int'(wr_req_b), 1);
      end
    end
  end

  // Stimulus and prediction.
  initial begin
    ms_t ma, mb, na, nb;
    me_t ea, eb;
    int phy_down;
    ma = '{default: 0};
    mb = '{default: 0};
    phy_down = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_req_a", wr_req_a == 1'b0, int'(wr_req_a), 0);
    chk("rst_rd_req_a", rd_req_a == 1'b0, int'(rd_req_a), 0);
    chk("rst_wr_gnt_a", wr_gnt_a == '0, int'(wr_gnt_a), 0);
    chk("rst_arbt_rdy_a", arbt_rdy_a == 1'b0, int'(arbt_rdy_a), 0);
    chk("rst_timeout_a", timeout_err_a == 1'b0, int'(timeout_err_a), 0);
    chk("rst_wr_req_b", wr_req_b == 1'b0, int'(wr_req_b), 0);
    chk("rst_rd_req_b", rd_req_b == 1'b0, int'(rd_req_b), 0);
    rst = 1'b0;
    cyc = 0;
    for (int k = 0; k < NCYC; k++) begin
      if (k < 200) begin
        tx_req = 4'b0001; rx_dat_type = sync; phyrdy = 1'b1; roll_insert = 1'b0;
        wr_cpl = 1'b0; wr_no_busy = 1'b0; rd_cpl = 1'b0;
      end else begin
        tx_req      = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        rx_dat_type = ($urandom_range(0, 3) == 0) ? x_rdy : sata_p_t'($urandom_range(0, 13));
        roll_insert = ($urandom_range(0, 39) == 0);
        wr_cpl      = ($urandom_range(0, 11) == 0);
        wr_no_busy  = ($urandom_range(0, 29) == 0);
        rd_cpl      = ($urandom_range(0, 11) == 0);
        if (phy_down > 0) begin
          phyrdy = 1'b0; phy_down--;
        end else if ($urandom_range(0, 1499) == 0) begin
          phyrdy = 1'b0; phy_down = $urandom_range(0, 4);
        end else begin
          phyrdy = 1'b1;
        end
      end
      exp_rdy = phyrdy && (ma.guard >= START);
      mstep(1, 1, ma, tx_req, rx_dat_type == x_rdy, phyrdy, roll_insert,
            wr_cpl, wr_no_busy, rd_cpl, na, ea);
      mstep(0, 0, mb, tx_req, rx_dat_type == x_rdy, phyrdy, roll_insert,
            wr_cpl, wr_no_busy, rd_cpl, nb, eb);
      push_ev(0, ea, k);
      push_ev(1, eb, k);
      ma = na;
      mb = nb;
      @(posedge clk);
      #1;
      cyc = k + 1;
    end
    @(negedge clk);
    #1;
    chk("sb_a_drained", qa.size() == 0, qa.size(), 0);
    chk("sb_b_drained", qb.size() == 0, qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
